// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: branch opcodes, FSM states
// and the sequential PC step.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGT  = 3'd3,
    BR_BLEZ = 3'd4,
    BR_BGTZ = 3'd5,
    BR_BLTZ = 3'd6,
    BR_BGEZ = 3'd7
  } br_op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Branch-in / redirect-out bundle of the branch resolve unit.
// The master side is the pipeline (ID stage plus fetch); the slave side is the unit.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  logic             Br_Valid;
  logic             Br_Ready;
  logic [2:0]       Br_Op;
  logic             Beq;
  logic             Blt;
  logic             Bgt;
  logic             Zero;
  logic             Bltz;
  logic             Bgtz;
  logic [31:0]      Br_PC;
  logic [31:0]      Br_Offset;
  logic             Redirect_Valid;
  logic             Redirect_Ready;
  logic [31:0]      Redirect_PC;
  logic             Flush;
  logic [CNT_W-1:0] Taken_Count;
  logic [CNT_W-1:0] NotTaken_Count;

  modport master (
    output Br_Valid, Br_Op, Beq, Blt, Bgt, Zero, Bltz, Bgtz, Br_PC, Br_Offset,
    output Redirect_Ready,
    input  Br_Ready, Redirect_Valid, Redirect_PC, Flush, Taken_Count, NotTaken_Count
  );

  modport slave (
    input  Br_Valid, Br_Op, Beq, Blt, Bgt, Zero, Bltz, Bgtz, Br_PC, Br_Offset,
    input  Redirect_Ready,
    output Br_Ready, Redirect_Valid, Redirect_PC, Flush, Taken_Count, NotTaken_Count
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational taken/not-taken decision from the branch opcode and comparator flags.
// Flags are trusted as presented; no cross-checking between them.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic       beq,
  input  logic       blt,
  input  logic       bgt,
  input  logic       zero,
  input  logic       bltz,
  input  logic       bgtz,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br_op_e'(br_op))
      BR_BEQ:  taken = beq;
      BR_BNE:  taken = ~beq;
      BR_BLT:  taken = blt;
      BR_BGT:  taken = bgt;
      BR_BLEZ: taken = zero | bltz;
      BR_BGTZ: taken = bgtz;
      BR_BLTZ: taken = bltz;
      BR_BGEZ: taken = zero | bgtz;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves ID-stage branches: flushes the wrong path, hands the target to fetch
// over valid/ready, and keeps saturating taken/not-taken statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  branch_resolve_unit_if.slave  bus
);

  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] not_taken_cnt_q, not_taken_cnt_d;

  logic             taken;
  logic             handshake;
  logic [31:0]      target;

  branch_cond_eval u_cond_eval (
    .br_op (bus.Br_Op),
    .beq   (bus.Beq),
    .blt   (bus.Blt),
    .bgt   (bus.Bgt),
    .zero  (bus.Zero),
    .bltz  (bus.Bltz),
    .bgtz  (bus.Bgtz),
    .taken (taken)
  );

  assign target    = bus.Br_PC + PC_STEP + (bus.Br_Offset << 2);
  assign handshake = redirect_valid_q & bus.Redirect_Ready;

  always_comb begin
    state_d          = state_q;
    redirect_pc_d    = redirect_pc_q;
    redirect_valid_d = redirect_valid_q;
    flush_cnt_d      = flush_cnt_q;
    taken_cnt_d      = taken_cnt_q;
    not_taken_cnt_d  = not_taken_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.Br_Valid) begin
          if (taken) begin
            redirect_pc_d    = target;
            redirect_valid_d = 1'b1;
            flush_cnt_d      = FLUSH_INIT;
            state_d          = ST_REDIRECT;
            if (taken_cnt_q != CNT_MAX) taken_cnt_d = taken_cnt_q + CNT_W'(1);
          end else if (not_taken_cnt_q != CNT_MAX) begin
            not_taken_cnt_d = not_taken_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_REDIRECT: begin
        if (flush_cnt_q != 3'd0) flush_cnt_d = flush_cnt_q - 3'd1;
        if (handshake) redirect_valid_d = 1'b0;
        // Leave only once fetch has the target and the flush window has drained.
        if ((handshake || !redirect_valid_q) && (flush_cnt_d == 3'd0)) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q          <= ST_IDLE;
      redirect_pc_q    <= 32'd0;
      redirect_valid_q <= 1'b0;
      flush_cnt_q      <= 3'd0;
      taken_cnt_q      <= '0;
      not_taken_cnt_q  <= '0;
    end else begin
      state_q          <= state_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
      flush_cnt_q      <= flush_cnt_d;
      taken_cnt_q      <= taken_cnt_d;
      not_taken_cnt_q  <= not_taken_cnt_d;
    end
  end

  assign bus.Br_Ready       = (state_q == ST_IDLE);
  assign bus.Redirect_Valid = redirect_valid_q;
  assign bus.Redirect_PC    = redirect_pc_q;
  assign bus.Flush          = (state_q == ST_REDIRECT) && (flush_cnt_q != 3'd0);
  assign bus.Taken_Count    = taken_cnt_q;
  assign bus.NotTaken_Count = not_taken_cnt_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the branch comparator flags.
- Takes the comparator outcome and the branch opcode of the instruction in ID, and decides whether the branch is taken.
- For a taken branch: computes the target, flushes the wrong-path instruction(s), and hands the redirect PC to the fetch stage over a valid/ready handshake.
- Keeps saturating taken / not-taken statistics for the lab performance report.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles Flush is held high per taken branch (legal range 1..7)
CNT_W, 16, width of each statistics counter

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset (one clock; Reset sampled on the Clk rising edge, 0 = reset)
Br_Valid  in  1  a branch instruction is presented this cycle
Br_Ready  out  1  unit can accept a branch this cycle
Br_Op  in  3  branch type: 0 BEQ, 1 BNE, 2 BLT, 3 BGT, 4 BLEZ, 5 BGTZ, 6 BLTZ, 7 BGEZ
Beq, Blt, Bgt  in  1 each  Reg1 ==/</> Reg2 flags from the comparator
Zero, Bltz, Bgtz  in  1 each  Reg1 ==0 / <0 / >0 flags from the comparator
Br_PC  in  32  address of the branch instruction
Br_Offset  in  32  sign-extended word offset
Redirect_Valid  out  1  Redirect_PC is valid
Redirect_Ready  in  1  fetch accepts the redirect
Redirect_PC  out  32  branch target
Flush  out  1  squash the IF/ID wrong-path instruction
Taken_Count  out  CNT_W  branches resolved taken
NotTaken_Count  out  CNT_W  branches resolved not taken

Behaviour:
- Reset (Reset=0 at a rising edge):
  - state=IDLE, Redirect_Valid=0, Flush=0, Redirect_PC=0, both counters=0, flush counter=0.
  - Br_Ready=1 from the first cycle after reset.
  - Reset asserted mid-REDIRECT abandons the redirect; no handshake completes and no counter changes.
- Taken condition (combinational on the flags):
  - BEQ: Beq. BNE: !Beq. BLT: Blt. BGT: Bgt.
  - BLEZ: Zero|Bltz. BGTZ: Bgtz. BLTZ: Bltz. BGEZ: Zero|Bgtz.
  - Flags are used exactly as presented; no consistency checking.
- Target: Br_PC + 4 + (Br_Offset << 2), truncated to 32 bits; wrap-around modulo 2^32 is legal.
- Accept: Br_Valid & Br_Ready at a rising edge. Br_Valid while Br_Ready=0 is ignored; upstream must hold the branch.
- IDLE (Br_Ready=1):
  - On accept, not taken: NotTaken_Count+1, remain IDLE. Back-to-back not-taken branches are accepted every cycle.
  - On accept, taken: register Redirect_PC, Taken_Count+1, load flush counter with FLUSH_CYCLES, go to REDIRECT.
- REDIRECT (Br_Ready=0):
  - Redirect_Valid=1; Redirect_PC held stable until the handshake completes.
  - Flush=1 while the flush counter is nonzero; the counter decrements each cycle.
  - The handshake completes on a cycle with Redirect_Valid & Redirect_Ready; Redirect_Valid=0 from the next cycle.
  - Return to IDLE on the edge where both the handshake has completed (now or earlier) and the flush counter reaches 0.
- Latency for a taken branch accepted at edge N:
  - Redirect_Valid and Flush are high in cycle N+1.
  - With Redirect_Ready=1 and FLUSH_CYCLES=1, the unit is in IDLE with Br_Ready=1 at N+2.
- Fetch backpressure: Flush deasserts after FLUSH_CYCLES cycles even if Redirect_Ready stays low; Redirect_Valid stays high until accepted.
- Counters: saturate at 2^CNT_W-1 and never wrap.
- All outputs are registered or derived only from state; there is no combinational path from Redirect_Ready to Redirect_Valid.

Decomposition:
- Shared package branch_pkg:
  - Br_Op encodings (BR_BEQ..BR_BGEZ).
  - FSM state encoding (ST_IDLE, ST_REDIRECT).
  - Constant PC_STEP=4.
- Sub-module branch_cond_eval: purely combinational; inputs Br_Op and the six flags, output taken. It is instantiated here and reusable by a later predictor-check block.

Test Plan:
1. Reset low for 2 cycles, then high -> all outputs 0, Br_Ready=1, both counters 0.
2. BEQ with Beq=1, Br_PC=0x00000100, Br_Offset=3, Redirect_Ready=1 -> cycle N+1: Redirect_PC=0x00000110, Redirect_Valid=1, Flush=1; Br_Ready=1 at N+2; Taken_Count=1.
3. Four back-to-back not-taken branches (BNE with Beq=1, BGTZ with Zero=1, BLTZ with Bgtz=1, BLT with Bgt=1) -> Br_Ready stays 1, Flush never high, NotTaken_Count=4.
4. Taken BGEZ with Zero=1, Br_PC=0xFFFFFFF8, Br_Offset=0, Redirect_Ready low for 3 cycles -> Redirect_PC=0xFFFFFFFC held stable; Flush high exactly 1 cycle; Br_Ready=0 until the cycle after Redirect_Ready rises.
5. FLUSH_CYCLES=3, taken BLEZ with Bltz=1, Br_Offset=0xFFFFFFFF, Br_PC=0x40 -> Redirect_PC=0x40; Flush high for cycles N+1..N+3; IDLE at N+4.
6. Reset asserted in the second cycle of REDIRECT -> Redirect_Valid=0 and Flush=0 in the next cycle, counters 0; CNT_W=2 run of 5 taken branches -> Taken_Count saturates at 3.
